fan_speed_ramp_sel: RTL and testbench
=====================================

Name: fan_speed_ramp_sel

Overview:
Parametrised successor to the fixed 5-way fan motor selector. It picks one of NUM_LEVELS PWM speed sources, with level 0 meaning motor off. Selection changes are applied only on PWM period boundaries, so the output never glitches. Upward changes soft-start one level at a time with a programmable dwell per step; downward changes jump straight to the target. It sits between the fan control FSM (which drives i_sel) and the motor driver pin.

Parameters:
- NUM_LEVELS, 4, number of non-zero speed levels / PWM inputs (>=1).
- SEL_W, 3, width of i_sel and o_level; must satisfy 2**SEL_W > NUM_LEVELS.
- DWELL_CYC, 1000, minimum clock cycles spent at each intermediate level while ramping up (>=1).
- DWELL_W, 10, width of the dwell counter; must satisfy 2**DWELL_W >= DWELL_CYC.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_x  in  NUM_LEVELS  PWM sources; i_x[k] drives speed level k+1.
- i_sel  in  SEL_W  requested level; 0 = off.
- i_period_tick  in  1  one-cycle pulse marking a PWM period boundary; level changes occur only on these cycles.
- o_motor  out  1  registered motor drive.
- o_level  out  SEL_W  currently applied level.
- o_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, cur_level=0, dwell counter=0, o_motor=0, o_level=0, o_busy=0. Assertion clears outputs immediately, with no clock edge needed.
- Target computation: target = i_sel when i_sel <= NUM_LEVELS; otherwise target = 0 (invalid codes mean off).
- o_motor is registered each cycle: 0 when cur_level==0, else i_x[cur_level-1]. Latency is one cycle from i_x or cur_level to o_motor.
- o_level = cur_level; o_busy = (state != IDLE).
- FSM states:
  - IDLE: if target != cur_level, go to STEP on the next cycle. i_period_tick is ignored in IDLE.
  - STEP: wait for i_period_tick. On a tick:
    - If target < cur_level: cur_level <= target, then go to IDLE.
    - If target > cur_level: cur_level <= cur_level+1, load counter with DWELL_CYC-1, then go to DWELL.
    - If target == cur_level: go to IDLE with no change.
  - DWELL: decrement the counter each cycle.
    - If target < cur_level at any time, abort and go to STEP.
    - When counter==0: go to IDLE if target==cur_level, else go to STEP.
- Consequences of these rules:
  - An upward step requires both the dwell to expire and a subsequent tick.
  - Minimum spacing between consecutive upward steps is max(DWELL_CYC+1, tick period) cycles.
  - Downward moves, including to 0, take exactly one tick and pass through no intermediate levels.
- Target change during DWELL to a value still above cur_level: the dwell completes, then the FSM continues toward the new target.
- A tick coincident with the counter reaching 0 is not used; the next tick is required.
- DWELL_CYC=1: DWELL lasts exactly one cycle.
- Ticks arriving in the IDLE, IDLE->STEP transition cycle, or DWELL are dropped; no tick queueing.

Optional Feature:
- Macro: FAN_SEL_SYNC_EN.
- Defined: i_sel passes through a 2-flop synchroniser (reset 0) before target computation, for asynchronous button or FSM sources. This adds 2 cycles of latency from i_sel to target.
- Undefined: i_sel is used directly and is assumed synchronous to i_clk.
- Ports and all other behaviour are identical in both builds.

Decomposition:
- Package fan_pkg holds:
  - the state enum (IDLE, STEP, DWELL);
  - a constant LEVEL_OFF = 0;
  - a clamp_level function that maps i_sel to target given NUM_LEVELS.
- One sub-module, fan_dwell_timer: a DWELL_W-bit down-counter with load, clear (abort) and a done flag.

Test Plan:
All scenarios use NUM_LEVELS=4, DWELL_CYC=4, and a tick every 8 cycles.
1. Hold i_rst_n=0 with i_sel=3, i_x=4'hF -> o_motor=0, o_level=0, o_busy=0 throughout; after release, level reaches 1 at the first tick after STEP is entered.
2. i_sel 0->4 with i_x=4'b1010 -> o_level steps 1,2,3,4 on successive ticks, 8 cycles apart. o_motor equals i_x[o_level-1] one cycle later. o_busy falls 4 cycles after level 4 is applied.
3. Settled at level 4, set i_sel=1 -> o_level goes 4->1 on the next tick with no intermediate values; o_busy low one cycle after.
4. i_sel=5, 6, 7 from level 2 -> o_level=0 and o_motor=0 after the next tick.
5. Ramp 0->4, then set i_sel=1 two cycles into the level-2 dwell -> dwell aborted, o_level=1 on the next tick, never reaches 3.
6. Assert i_rst_n low mid-ramp at level 3 between clock edges -> o_motor, o_level and o_busy are 0 immediately; after release, the FSM restarts from IDLE.

Source files
------------

// File: rtl/fan_pkg.sv
// fan_pkg: shared types and helpers for the fan speed ramp selector.
//   fan_state_t  - ramp controller states (IDLE, STEP, DWELL)
//   LEVEL_OFF    - level code meaning motor off
//   clamp_level  - maps a raw selector code to a target level; codes above
//                  num_levels are treated as off
package fan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        DWELL = 2'd2
    } fan_state_t;

    localparam int unsigned LEVEL_OFF = 0;

    function automatic int unsigned clamp_level(input int unsigned sel,
                                                input int unsigned num_levels);
        return (sel <= num_levels) ? sel : LEVEL_OFF;
    endfunction

endpackage

// File: rtl/fan_dwell_timer.sv
// fan_dwell_timer: down-counter timing the dwell spent at each intermediate
// level while the fan ramps up.
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset
//   load      load counter with load_val (wins over en)
//   clear     abort: force counter to zero (wins over load)
//   en        decrement while non-zero
//   load_val  reload value (dwell length minus one)
//   done      counter is zero
module fan_dwell_timer #(
    parameter int unsigned DWELL_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               clear,
    input  logic               en,
    input  logic [DWELL_W-1:0] load_val,
    output logic               done
);

    logic [DWELL_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - DWELL_W'(1);
        end
    end

    always_comb begin
        done = (count == '0);
    end

endmodule

// File: rtl/fan_speed_ramp_sel.sv
// fan_speed_ramp_sel: selects one of NUM_LEVELS PWM speed sources for the fan
// motor. Level changes are applied only on PWM period boundaries; upward
// changes soft-start one level per step with a dwell, downward changes jump
// straight to the target.
// Build option: define FAN_SEL_SYNC_EN to pass i_sel through a 2-flop
// synchroniser (adds 2 cycles of latency) for asynchronous selector sources.
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_x            PWM sources; i_x[k] drives speed level k+1
//   i_sel          requested level, 0 = off, codes above NUM_LEVELS = off
//   i_period_tick  one-cycle PWM period boundary pulse
//   o_motor        registered motor drive
//   o_level        currently applied level
//   o_busy         controller not idle
module fan_speed_ramp_sel
    import fan_pkg::*;
#(
    parameter int unsigned NUM_LEVELS = 4,
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned DWELL_CYC  = 1000,
    parameter int unsigned DWELL_W    = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_LEVELS-1:0] i_x,
    input  logic [SEL_W-1:0]      i_sel,
    input  logic                  i_period_tick,
    output logic                  o_motor,
    output logic [SEL_W-1:0]      o_level,
    output logic                  o_busy
);

    fan_state_t       state, next_state;
    logic [SEL_W-1:0] cur_level, level_nxt;
    logic [SEL_W-1:0] sel_sync;
    logic [SEL_W-1:0] target;
    logic             dwell_load, dwell_clear, dwell_done;
    logic             motor_nxt;

`ifdef FAN_SEL_SYNC_EN
    logic [SEL_W-1:0] sel_meta;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sel_meta <= '0;
            sel_sync <= '0;
        end else begin
            sel_meta <= i_sel;
            sel_sync <= sel_meta;
        end
    end
`else
    always_comb begin
        sel_sync = i_sel;
    end
`endif

    always_comb begin
        target = SEL_W'(clamp_level(32'(sel_sync), NUM_LEVELS));
    end

    fan_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .load     (dwell_load),
        .clear    (dwell_clear),
        .en       (state == DWELL),
        .load_val (DWELL_W'(DWELL_CYC - 1)),
        .done     (dwell_done)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            cur_level <= '0;
        end else begin
            state     <= next_state;
            cur_level <= level_nxt;
        end
    end

    always_comb begin
        next_state  = state;
        level_nxt   = cur_level;
        dwell_load  = 1'b0;
        dwell_clear = 1'b0;
        unique case (state)
            IDLE: begin
                if (target != cur_level) begin
                    next_state = STEP;
                end
            end
            STEP: begin
                if (i_period_tick) begin
                    if (target < cur_level) begin
                        level_nxt  = target;
                        next_state = IDLE;
                    end else if (target > cur_level) begin
                        level_nxt  = cur_level + SEL_W'(1);
                        dwell_load = 1'b1;
                        next_state = DWELL;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            DWELL: begin
                // A downward request abandons the dwell at once; an upward
                // change of target lets the dwell run out first.
                if (target < cur_level) begin
                    dwell_clear = 1'b1;
                    next_state  = STEP;
                end else if (dwell_done) begin
                    next_state = (target == cur_level) ? IDLE : STEP;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Decoded as a compare per level so the index never leaves i_x's range.
    always_comb begin
        motor_nxt = 1'b0;
        for (int unsigned k = 0; k < NUM_LEVELS; k++) begin
            if (cur_level == SEL_W'(k + 1)) begin
                motor_nxt = i_x[k];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_motor <= 1'b0;
        end else begin
            o_motor <= motor_nxt;
        end
    end

    always_comb begin
        o_level = cur_level;
        o_busy  = (state != IDLE);
    end

endmodule

// File: tb/tb_fan_speed_ramp_sel.sv
// tb_fan_speed_ramp_sel: directed bench for fan_speed_ramp_sel with
// NUM_LEVELS=4, DWELL_CYC=4 and a period tick every 8 cycles. Expected
// observations are queued with the cycle they are due in and compared on
// the falling clock edge of that cycle.
module tb_fan_speed_ramp_sel;

    localparam int unsigned NL = 4;
    localparam int unsigned SW = 3;
    localparam int unsigned DC = 4;
    localparam int unsigned DW = 3;
    localparam int unsigned TP = 8;

    localparam int unsigned K_LEVEL = 0;
    localparam int unsigned K_MOTOR = 1;
    localparam int unsigned K_BUSY  = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          tick  = 1'b0;
    logic [NL-1:0] x     = '0;
    logic [SW-1:0] sel   = '0;
    logic          motor;
    logic [SW-1:0] level;
    logic          busy;

    int unsigned cyc       = 0;
    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    typedef struct packed {
        int unsigned cyc;
        int unsigned tag;
        int unsigned kind;
        int unsigned val;
    } exp_t;

    exp_t sb[$];

    fan_speed_ramp_sel #(
        .NUM_LEVELS (NL),
        .SEL_W      (SW),
        .DWELL_CYC  (DC),
        .DWELL_W    (DW)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_x           (x),
        .i_sel         (sel),
        .i_period_tick (tick),
        .o_motor       (motor),
        .o_level       (level),
        .o_busy        (busy)
    );

    // Cycle n runs from rising edge n to rising edge n+1; the tick is high
    // throughout every cycle that is a multiple of TP.
    always begin
        #5;
        cyc = cyc + 1;
        clk = 1'b1;
        #1;
        tick = (cyc % TP == 0);
        #4;
        clk = 1'b0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    function automatic string kname(input int unsigned k);
        case (k)
            K_LEVEL: return "level";
            K_MOTOR: return "motor";
            default: return "busy";
        endcase
    endfunction

    function automatic int unsigned next_tick(input int unsigned c);
        return ((c + TP - 1) / TP) * TP;
    endfunction

    task automatic push(input int unsigned c, input int unsigned tg,
                        input int unsigned k, input int unsigned v);
        sb.push_back('{cyc: c, tag: tg, kind: k, val: v});
    endtask

    task automatic check_entry(input exp_t e);
        logic [31:0] obs;
        case (e.kind)
            K_LEVEL: obs = {29'b0, level};
            K_MOTOR: obs = {31'b0, motor};
            default: obs = {31'b0, busy};
        endcase
        total_cnt++;
        assert (e.cyc == cyc && obs === e.val) pass_cnt++;
        else $error("FAIL t%0d_%s at cycle %0d (due %0d): observed %0d, expected %0d",
                    e.tag, kname(e.kind), cyc, e.cyc, obs, e.val);
    endtask

    always @(negedge clk) begin : scoreboard
        int unsigned i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc <= cyc) begin
                check_entry(sb[i]);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic chk_now(input int unsigned tg, input logic [SW-1:0] lv,
                           input logic mt, input logic bs);
        total_cnt++;
        assert (level === lv) pass_cnt++;
        else $error("FAIL t%0d_now_level: observed %0d, expected %0d", tg, level, lv);
        total_cnt++;
        assert (motor === mt) pass_cnt++;
        else $error("FAIL t%0d_now_motor: observed %0d, expected %0d", tg, motor, mt);
        total_cnt++;
        assert (busy === bs) pass_cnt++;
        else $error("FAIL t%0d_now_busy: observed %0d, expected %0d", tg, busy, bs);
    endtask

    task automatic goto_cyc(input int unsigned n);
        while (cyc < n) @(posedge clk);
        #2;
    endtask

    // Expectations for an upward ramp requested in cycle s: the request is
    // seen in IDLE at cycle s, STEP from s+1, each step lands on the cycle
    // after a tick, then DC dwell cycles, then STEP again waiting for a tick.
    // Returns the tick cycle of the last step.
    task automatic ramp_expect(input int unsigned tg, input int unsigned from,
                               input int unsigned to, input int unsigned s,
                               input bit settle, input logic [NL-1:0] xv,
                               output int unsigned t);
        t = next_tick(s + 1);
        for (int unsigned l = from + 1; l <= to; l++) begin
            if (l != from + 1) t = next_tick(t + DC + 1);
            push(t, tg, K_BUSY, 1);
            push(t + 1, tg, K_LEVEL, l);
            push(t + 2, tg, K_MOTOR, {31'b0, xv[l-1]});
        end
        if (settle) begin
            push(t + DC, tg, K_BUSY, 1);
            push(t + DC + 1, tg, K_BUSY, 0);
            push(t + DC + 1, tg, K_LEVEL, to);
        end
    endtask

    // Expectations for a downward move requested in cycle s: the level holds
    // until the first tick in STEP, then jumps directly to the target.
    task automatic down_expect(input int unsigned tg, input int unsigned from,
                               input int unsigned to, input int unsigned s,
                               input logic [NL-1:0] xv, output int unsigned t);
        t = next_tick(s + 1);
        for (int unsigned c = s + 1; c <= t; c++) push(c, tg, K_LEVEL, from);
        push(t, tg, K_BUSY, 1);
        push(t + 1, tg, K_LEVEL, to);
        push(t + 1, tg, K_BUSY, 0);
        push(t + 2, tg, K_MOTOR, (to == 0) ? 0 : {31'b0, xv[to-1]});
    endtask

    initial begin
        int unsigned e, t, t2, r;

        // 1: reset holds everything at zero, then ramp to 3 after release
        x   = 4'hF;
        sel = 3'd3;
        #1 rst_n = 1'b0;
        #1 chk_now(1, 0, 1'b0, 1'b0);
        for (int unsigned c = 1; c <= 3; c++) begin
            push(c, 1, K_LEVEL, 0);
            push(c, 1, K_MOTOR, 0);
            push(c, 1, K_BUSY, 0);
        end
        goto_cyc(3);
        rst_n = 1'b1;
        push(4, 1, K_BUSY, 1);
        ramp_expect(1, 0, 3, 3, 1'b1, x, t);
        e = t + DC + 1;

        // 2: back to off, then soft-start 0 -> 4 with x = 1010
        goto_cyc(e + 1);
        x   = 4'b1010;
        sel = 3'd0;
        down_expect(2, 3, 0, e + 1, x, t);
        e = t + 1;
        goto_cyc(e + 1);
        sel = 3'd4;
        ramp_expect(2, 0, 4, e + 1, 1'b1, x, t);
        e = t + DC + 1;

        // 3: 4 -> 1 in a single tick
        goto_cyc(e + 1);
        x   = 4'b0011;
        sel = 3'd1;
        down_expect(3, 4, 1, e + 1, x, t);
        e = t + 1;

        // 4: invalid codes 5..7 from level 2 turn the motor off
        goto_cyc(e + 1);
        sel = 3'd2;
        ramp_expect(4, 1, 2, e + 1, 1'b1, x, t);
        e = t + DC + 1;
        for (int unsigned code = 5; code <= 7; code++) begin
            goto_cyc(e + 1);
            sel = SW'(code);
            down_expect(4, 2, 0, e + 1, x, t);
            e = t + 1;
            goto_cyc(e + 1);
            sel = 3'd2;
            ramp_expect(4, 0, 2, e + 1, 1'b1, x, t);
            e = t + DC + 1;
        end

        // 5: drop to 1 two cycles into the level-2 dwell of a ramp to 4
        goto_cyc(e + 1);
        sel = 3'd0;
        down_expect(5, 2, 0, e + 1, x, t);
        e = t + 1;
        goto_cyc(e + 1);
        sel = 3'd4;
        ramp_expect(5, 0, 2, e + 1, 1'b0, x, t2);
        t = next_tick(t2 + 3);
        for (int unsigned c = t2 + 1; c <= t; c++) push(c, 5, K_LEVEL, 2);
        push(t, 5, K_BUSY, 1);
        for (int unsigned c = t + 1; c <= t + 4; c++) push(c, 5, K_LEVEL, 1);
        push(t + 1, 5, K_BUSY, 0);
        push(t + 2, 5, K_MOTOR, {31'b0, x[0]});
        goto_cyc(t2 + 2);
        sel = 3'd1;
        e = t + 4;

        // 6: asynchronous reset mid-ramp at level 3, then restart from IDLE
        goto_cyc(e + 1);
        x   = 4'hF;
        sel = 3'd4;
        ramp_expect(6, 1, 3, e + 1, 1'b0, x, t);
        goto_cyc(t + 3);
        chk_now(6, 3, 1'b1, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk_now(6, 0, 1'b0, 1'b0);
        push(t + 4, 6, K_LEVEL, 0);
        push(t + 4, 6, K_MOTOR, 0);
        push(t + 4, 6, K_BUSY, 0);
        goto_cyc(t + 5);
        rst_n = 1'b1;
        r = t + 5;
        push(r, 6, K_BUSY, 0);
        push(r + 1, 6, K_BUSY, 1);
        ramp_expect(6, 0, 4, r, 1'b1, x, t);
        e = t + DC + 1;

        goto_cyc(e + 2);
        total_cnt++;
        assert (sb.size() == 0) pass_cnt++;
        else $error("FAIL sb_drain: observed %0d pending, expected 0", sb.size());

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
